// File: rtl/mac_result_sink.sv
// Receiving end of the MAC output stream: adds per-neuron bias, rounds, shifts,
// applies optional ReLU, saturates, and assembles the next layer's input vector.
module mac_result_sink #(
    parameter int DATA_W   = 16,
    parameter int N_IN     = 128,
    parameter int N_HIDDEN = 64,
    parameter int N_LAYERS = 3,
    parameter int SHIFT    = 8,
    localparam int ACC_W   = 2*DATA_W + $clog2(N_IN),
    localparam int HID_W   = $clog2(N_HIDDEN),
    localparam int LAY_W   = $clog2(N_LAYERS),
    localparam int ADDR_W  = $clog2(N_LAYERS*N_HIDDEN)
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       start,
    input  logic [LAY_W-1:0]           layer_idx,
    input  logic                       relu_en,
    input  logic signed [ACC_W-1:0]    in_data,
    input  logic                       in_valid,
    output logic                       in_ready,
    output logic [ADDR_W-1:0]          bmem_raddr,
    input  logic signed [DATA_W-1:0]   bmem_rdata,
    output logic [N_HIDDEN*DATA_W-1:0] outvec_bus,
    output logic                       vec_valid,
    input  logic                       vec_ack,
    output logic                       busy,
    output logic [HID_W:0]             sat_count
);
    localparam int SW = ACC_W + DATA_W + 2;

    localparam logic [1:0] IDLE    = 2'd0;
    localparam logic [1:0] COLLECT = 2'd1;
    localparam logic [1:0] DRAIN   = 2'd2;
    localparam logic [1:0] DONE    = 2'd3;

    localparam logic [HID_W-1:0] LAST = HID_W'(N_HIDDEN - 1);
    localparam logic signed [SW-1:0] RND =
        (SHIFT > 0) ? (SW'(1) << (SHIFT > 0 ? SHIFT - 1 : 0)) : '0;
    localparam logic signed [SW-1:0] MAXV =
        {{(SW-DATA_W+1){1'b0}}, {(DATA_W-1){1'b1}}};
    localparam logic signed [SW-1:0] MINV =
        {{(SW-DATA_W+1){1'b1}}, {(DATA_W-1){1'b0}}};

    logic [1:0]                         state;
    logic [HID_W-1:0]                   cnt;
    logic [LAY_W-1:0]                   lay;
    logic                               relu;
    logic                               s1_valid;
    logic signed [ACC_W-1:0]            s1_data;
    logic [HID_W-1:0]                   s1_k;
    logic [N_HIDDEN-1:0][DATA_W-1:0]    vec;
    logic                               accept;

    logic signed [SW-1:0]               s;
    logic signed [SW-1:0]               r;
    logic signed [SW-1:0]               b;
    logic [DATA_W-1:0]                  res;
    logic                               clip;

    assign in_ready   = (state == COLLECT);
    assign vec_valid  = (state == DONE);
    assign busy       = (state != IDLE);
    assign accept     = in_valid && in_ready;
    assign outvec_bus = vec;
    assign bmem_raddr = (state == COLLECT)
        ? ADDR_W'(lay) * ADDR_W'(N_HIDDEN) + ADDR_W'(cnt)
        : '0;

    // Bias arrives one cycle after its address, aligned with stage 1.
    always_comb begin
        b    = {{(SW-DATA_W){bmem_rdata[DATA_W-1]}}, bmem_rdata};
        s    = {{(SW-ACC_W){s1_data[ACC_W-1]}}, s1_data};
        s    = s + (b <<< SHIFT) + RND;
        r    = s >>> SHIFT;
        clip = 1'b0;
        if (relu && r < 0)
            r = '0;
        res = r[DATA_W-1:0];
        if (r > MAXV) begin
            res  = MAXV[DATA_W-1:0];
            clip = 1'b1;
        end else if (r < MINV) begin
            res  = MINV[DATA_W-1:0];
            clip = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            cnt       <= '0;
            lay       <= '0;
            relu      <= 1'b0;
            s1_valid  <= 1'b0;
            s1_data   <= '0;
            s1_k      <= '0;
            vec       <= '0;
            sat_count <= '0;
        end else begin
            s1_valid <= accept;
            if (accept) begin
                s1_data <= in_data;
                s1_k    <= cnt;
                cnt     <= cnt + 1'b1;
            end
            if (s1_valid) begin
                vec[s1_k] <= res;
                if (clip)
                    sat_count <= sat_count + 1'b1;
            end
            unique case (state)
                IDLE: if (start) begin
                    lay       <= layer_idx;
                    relu      <= relu_en;
                    cnt       <= '0;
                    vec       <= '0;
                    sat_count <= '0;
                    state     <= COLLECT;
                end
                COLLECT: if (accept && cnt == LAST)
                    state <= DRAIN;
                DRAIN: state <= DONE;
                DONE: if (vec_ack)
                    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_mac_result_sink.sv
// Directed bench for mac_result_sink: rounding, bias, ReLU, saturation,
// bubbles, handshake, ignored starts and mid-layer reset.
module tb_mac_result_sink;
    localparam int DW = 16;
    localparam int NH = 64;
    localparam int NL = 3;
    localparam int ACC_W = 39;

    logic                    clk = 1'b0;
    logic                    rst;
    logic                    start;
    logic [1:0]              layer_idx;
    logic                    relu_en;
    logic signed [ACC_W-1:0] in_data;
    logic                    in_valid;
    logic                    in_ready;
    logic [7:0]              bmem_raddr;
    logic signed [DW-1:0]    bmem_rdata;
    logic [NH*DW-1:0]        outvec_bus;
    logic                    vec_valid;
    logic                    vec_ack;
    logic                    busy;
    logic [6:0]              sat_count;

    int vectors = 0;
    int miscompares = 0;
    longint words [NH];
    longint expv [NH];
    logic signed [DW-1:0] bmem [NL*NH];

    mac_result_sink dut (
        .clk(clk), .rst(rst), .start(start), .layer_idx(layer_idx),
        .relu_en(relu_en), .in_data(in_data), .in_valid(in_valid),
        .in_ready(in_ready), .bmem_raddr(bmem_raddr),
        .bmem_rdata(bmem_rdata), .outvec_bus(outvec_bus),
        .vec_valid(vec_valid), .vec_ack(vec_ack), .busy(busy),
        .sat_count(sat_count)
    );

    always #5 clk = ~clk;

    always @(posedge clk)
        bmem_rdata <= (bmem_raddr < NL*NH) ? bmem[bmem_raddr] : '0;

    task automatic chk(input string tag, input logic signed [63:0] obs,
                       input logic signed [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    function automatic logic signed [63:0] elem(input int k);
        logic signed [DW-1:0] e;
        e = outvec_bus[k*DW +: DW];
        return e;
    endfunction

    task automatic check_vec(input string tag);
        for (int k = 0; k < NH; k++)
            chk($sformatf("%s[%0d]", tag, k), elem(k), expv[k]);
    endtask

    task automatic start_layer(input int lay, input bit relu);
        start = 1'b1;
        layer_idx = 2'(lay);
        relu_en = relu;
        @(negedge clk);
        start = 1'b0;
        chk("busy_after_start", busy, 1);
        chk("ready_after_start", in_ready, 1);
    endtask

    // Offers words[0..n-1]; returns at the negedge after the last accept.
    task automatic feed(input bit rnd, input int base, input int n);
        int k = 0;
        int budget = 2000;
        while (k < n && budget > 0) begin
            in_data = ACC_W'(words[k]);
            in_valid = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            if (rnd && k == 10) begin
                start = 1'b1;
                layer_idx = 2'd0;
                relu_en = 1'b1;
            end else begin
                start = 1'b0;
            end
            if (in_valid && in_ready) begin
                chk("raddr", bmem_raddr, base + k);
                k++;
            end
            @(negedge clk);
            budget--;
        end
        start = 1'b0;
        if (k < n)
            chk("feed_timeout", k, n);
    endtask

    task automatic finish_layer();
        chk("drain_vec_valid", vec_valid, 0);
        chk("drain_in_ready", in_ready, 0);
        @(negedge clk);
        chk("done_vec_valid", vec_valid, 1);
        chk("done_in_ready", in_ready, 0);
    endtask

    task automatic ack();
        vec_ack = 1'b1;
        @(negedge clk);
        vec_ack = 1'b0;
        chk("ack_vec_valid", vec_valid, 0);
        chk("ack_busy", busy, 0);
    endtask

    initial begin
        rst = 1'b1;
        start = 1'b0;
        layer_idx = '0;
        relu_en = 1'b0;
        in_data = '0;
        in_valid = 1'b0;
        vec_ack = 1'b0;
        for (int i = 0; i < NL*NH; i++) bmem[i] = '0;
        bmem[0] = 16'sd2;
        bmem[NH+3] = 16'sd1;
        for (int k = 0; k < NH; k++) bmem[2*NH+k] = DW'(k);

        repeat (2) @(negedge clk);
        rst = 1'b0;
        chk("rst_in_ready", in_ready, 0);
        chk("rst_vec_valid", vec_valid, 0);
        chk("rst_busy", busy, 0);
        chk("rst_sat", sat_count, 0);
        chk("rst_bus", outvec_bus == '0, 1);
        chk("rst_raddr", bmem_raddr, 0);

        // Layer 0: rounding, bias, saturation without ReLU
        for (int k = 0; k < NH; k++) begin words[k] = 0; expv[k] = 0; end
        words[0] = 4736;      expv[0] = 21;
        words[1] = -384;      expv[1] = -1;
        words[2] = -5000;     expv[2] = -20;
        words[3] = 1 << 30;   expv[3] = 32767;
        words[4] = -(1 << 30); expv[4] = -32768;
        words[5] = 300;       expv[5] = 1;
        words[6] = -128;      expv[6] = 0;
        words[7] = -129;      expv[7] = -1;
        words[63] = 128;      expv[63] = 1;
        start_layer(0, 1'b0);
        feed(1'b0, 0, NH);
        in_valid = 1'b0;
        finish_layer();
        check_vec("l0");
        chk("l0_sat", sat_count, 2);
        ack();

        // Layer 1: ReLU, bias from the second set
        for (int k = 0; k < NH; k++) begin words[k] = 0; expv[k] = 0; end
        words[0] = -5000;
        words[1] = -(1 << 30);
        words[2] = 1 << 30;   expv[2] = 32767;
        words[3] = 1000;      expv[3] = 5;
        start_layer(1, 1'b1);
        feed(1'b0, NH, NH);
        in_valid = 1'b0;
        finish_layer();
        check_vec("l1");
        chk("l1_sat", sat_count, 1);
        ack();

        // Layer 2: random bubbles, ignored starts, held ack
        for (int k = 0; k < NH; k++) begin
            words[k] = longint'(k) << 8;
            expv[k] = 2 * k;
        end
        start_layer(2, 1'b0);
        feed(1'b1, 2*NH, NH);
        in_valid = 1'b1;
        finish_layer();
        for (int i = 0; i < 20; i++) begin
            start = (i == 5);
            layer_idx = 2'd1;
            @(negedge clk);
            start = 1'b0;
            chk("hold_vec_valid", vec_valid, 1);
            chk("hold_in_ready", in_ready, 0);
            check_vec("hold");
        end
        chk("l2_sat", sat_count, 0);
        start = 1'b1;
        ack();
        start = 1'b0;
        in_valid = 1'b0;
        @(negedge clk);
        chk("ack_start_ignored", busy, 0);

        // Mid-layer reset after 30 saturating words
        for (int k = 0; k < NH; k++) words[k] = 1 << 30;
        start_layer(2, 1'b0);
        feed(1'b0, 2*NH, 30);
        in_valid = 1'b0;
        chk("pre_rst_sat", sat_count, 29);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("mid_rst_in_ready", in_ready, 0);
        chk("mid_rst_vec_valid", vec_valid, 0);
        chk("mid_rst_busy", busy, 0);
        chk("mid_rst_sat", sat_count, 0);
        chk("mid_rst_bus", outvec_bus == '0, 1);
        chk("mid_rst_raddr", bmem_raddr, 0);

        for (int k = 0; k < NH; k++) begin
            words[k] = longint'(k) << 8;
            expv[k] = k;
        end
        expv[3] = 4;
        start_layer(1, 1'b0);
        feed(1'b0, NH, NH);
        in_valid = 1'b0;
        finish_layer();
        check_vec("post_rst");
        chk("post_rst_sat", sat_count, 0);
        ack();

        $display("== %0d vectors applied, %0d miscompares ==",
                 vectors, miscompares);
        $finish;
    end
endmodule
